// File: rtl/general_register_file_pkg.sv
// Shared definitions for the multi-port general register file.
// Optional same-cycle write-to-read forwarding: GENERAL_REGISTER_FILE_BYPASS_EN.
package general_register_file_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          NREGS_DEF    = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          ZERO_IDX     = 0;

  // Register index type for the default-sized register file
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/general_register_file_mp_if.sv
// Bus between the core (issue/decode/writeback) and the register file.
// Optional same-cycle write-to-read forwarding: GENERAL_REGISTER_FILE_BYPASS_EN.
interface general_register_file_mp_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_idx;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_idx;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_idx;
  logic                   iss_stall;
  logic [XLEN-1:0]        pc_read_data;
  logic [XLEN-1:0]        pc_write_data;
  logic                   pc_write_enable;
  logic [AW-1:0]          dbg_idx;
  logic [XLEN-1:0]        dbg_data;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_data, iss_en, iss_idx,
           pc_write_data, pc_write_enable, dbg_idx,
    input  rd_data, rd_busy, iss_stall, pc_read_data, dbg_data
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_data, iss_en, iss_idx,
           pc_write_data, pc_write_enable, dbg_idx,
    output rd_data, rd_busy, iss_stall, pc_read_data, dbg_data
  );

endinterface

// File: rtl/general_register_file_mp_rf_scoreboard.sv
// Busy scoreboard: one bit per register marking a write in flight.
// With GENERAL_REGISTER_FILE_BYPASS_EN a same-cycle writeback hides the busy bit in lookups.
module rf_scoreboard
  import general_register_file_pkg::*;
#(
  parameter int  NREGS  = 32,
  parameter int  NUM_RD = 2,
  parameter int  NUM_WR = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en_i,
  input  logic [AW-1:0]        iss_idx_i,
  input  logic [NUM_WR-1:0]    wr_en_i,
  input  logic [NUM_WR*AW-1:0] wr_idx_i,
  input  logic [NUM_RD*AW-1:0] rd_idx_i,
  output logic [NUM_RD-1:0]    rd_busy_o,
  output logic                 iss_stall_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] clr_s;
  logic [NREGS-1:0] view_s;
  logic             set_ok_s;

  // Decode every writeback strobe into a per-register clear request
  always_comb begin
    clr_s = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en_i[w]) begin
        clr_s[wr_idx_i[w*AW +: AW]] = 1'b1;
      end else begin
        clr_s = clr_s;
      end
    end
  end

  // Issue claims only a free nonzero register (new owner beats same-cycle clear); a busy one can only be cleared
  always_comb begin
    set_ok_s = iss_en_i && (iss_idx_i != AW'(ZERO_IDX)) && !busy_q[iss_idx_i];
    busy_d   = busy_q & ~clr_s;
    if (set_ok_s) begin
      busy_d[iss_idx_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[ZERO_IDX] = 1'b0;
  end

  // Busy bit state, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef GENERAL_REGISTER_FILE_BYPASS_EN
  assign view_s = busy_q & ~clr_s;
`else
  assign view_s = busy_q;
`endif

  // Per-port busy lookups and issue stall against the visible busy view
  always_comb begin
    rd_busy_o = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_busy_o[p] = view_s[rd_idx_i[p*AW +: AW]];
    end
    iss_stall_o = view_s[iss_idx_i];
  end

endmodule

// File: rtl/general_register_file_mp.sv
// Multi-port general register file with PC and busy scoreboard; x0 reads as zero.
// Optional same-cycle write-to-read forwarding: GENERAL_REGISTER_FILE_BYPASS_EN.
module general_register_file_mp
  import general_register_file_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              NREGS    = NREGS_DEF,
  parameter int              NUM_RD   = 2,
  parameter int              NUM_WR   = 1,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input logic                        clk,
  input logic                        rst,
  general_register_file_mp_if.slave  bus
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]        regs_q [NREGS];
  logic [XLEN-1:0]        regs_d [NREGS];
  logic [XLEN-1:0]        pc_q;
  logic [XLEN-1:0]        pc_d;
  logic [NUM_RD*XLEN-1:0] rd_data_s;

  // Merge writeback ports into next register state; later ports override earlier ones
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_en[w] && (bus.wr_idx[w*AW +: AW] != AW'(ZERO_IDX))) begin
        regs_d[bus.wr_idx[w*AW +: AW]] = bus.wr_data[w*XLEN +: XLEN];
      end else begin
        regs_d[ZERO_IDX] = '0;
      end
    end
    regs_d[ZERO_IDX] = '0;
  end

  // Next PC: load on enable, otherwise hold
  always_comb begin
    if (bus.pc_write_enable) begin
      pc_d = bus.pc_write_data;
    end else begin
      pc_d = pc_q;
    end
  end

  // Register array and PC state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      pc_q <= RESET_PC;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
      end
      pc_q <= pc_d;
    end
  end

  // Combinational read ports, optionally forwarding a same-cycle writeback
  always_comb begin
    rd_data_s = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.rd_idx[p*AW +: AW] != AW'(ZERO_IDX)) begin
        rd_data_s[p*XLEN +: XLEN] = regs_q[bus.rd_idx[p*AW +: AW]];
`ifdef GENERAL_REGISTER_FILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_en[w] && (bus.wr_idx[w*AW +: AW] == bus.rd_idx[p*AW +: AW])) begin
            rd_data_s[p*XLEN +: XLEN] = bus.wr_data[w*XLEN +: XLEN];
          end else begin
            rd_data_s = rd_data_s;
          end
        end
`endif
      end else begin
        rd_data_s[p*XLEN +: XLEN] = '0;
      end
    end
  end

  assign bus.rd_data      = rd_data_s;
  assign bus.pc_read_data = pc_q;
  assign bus.dbg_data     = regs_q[bus.dbg_idx];

  rf_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .iss_en_i    (bus.iss_en),
    .iss_idx_i   (bus.iss_idx),
    .wr_en_i     (bus.wr_en),
    .wr_idx_i    (bus.wr_idx),
    .rd_idx_i    (bus.rd_idx),
    .rd_busy_o   (bus.rd_busy),
    .iss_stall_o (bus.iss_stall)
  );

endmodule

// File: tb/tb_general_register_file_mp.sv
// Self-checking bench for general_register_file_mp (2 read, 2 write ports).
// Honours GENERAL_REGISTER_FILE_BYPASS_EN in its reference model.
module tb_general_register_file_mp;

  localparam int          XL  = 32;
  localparam int          NR  = 32;
  localparam int          NRD = 2;
  localparam int          NWR = 2;
  localparam int          AWL = 5;
  localparam logic [31:0] RPC = 32'h0000_0080;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  // reference model state
  logic [31:0] m_regs [NR];
  logic [31:0] m_busy;
  logic [31:0] m_pc;

  general_register_file_mp_if #(.XLEN(XL), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) rf_if ();

  general_register_file_mp #(
    .XLEN(XL), .NREGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .RESET_PC(RPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read data: stored value, or the highest-numbered matching write when forwarding
  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    logic [31:0] v;
    if (idx == 5'd0) return 32'd0;
    v = m_regs[idx];
`ifdef GENERAL_REGISTER_FILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (rf_if.wr_en[w] && rf_if.wr_idx[w*AWL +: AWL] == idx) v = rf_if.wr_data[w*XL +: XL];
`endif
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx);
    logic b;
    if (idx == 5'd0) return 1'b0;
    b = m_busy[idx];
`ifdef GENERAL_REGISTER_FILE_BYPASS_EN
    for (int w = 0; w < NWR; w++)
      if (rf_if.wr_en[w] && rf_if.wr_idx[w*AWL +: AWL] == idx) b = 1'b0;
`endif
    return b;
  endfunction

  task automatic idle();
    rf_if.rd_idx          = '0;
    rf_if.wr_en           = '0;
    rf_if.wr_idx          = '0;
    rf_if.wr_data         = '0;
    rf_if.iss_en          = 1'b0;
    rf_if.iss_idx         = '0;
    rf_if.pc_write_data   = '0;
    rf_if.pc_write_enable = 1'b0;
    rf_if.dbg_idx         = '0;
  endtask

  // Advance one clock and apply the architectural rules to the model
  task automatic tick();
    logic [31:0] old_busy;
    logic [4:0]  wi;
    @(posedge clk);
    old_busy = m_busy;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_regs[r] = 32'd0;
      m_busy = 32'd0;
      m_pc   = RPC;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        wi = rf_if.wr_idx[w*AWL +: AWL];
        if (rf_if.wr_en[w]) begin
          if (wi != 5'd0) m_regs[wi] = rf_if.wr_data[w*XL +: XL];
          m_busy[wi] = 1'b0;
        end
      end
      if (rf_if.iss_en && rf_if.iss_idx != 5'd0 && !old_busy[rf_if.iss_idx])
        m_busy[rf_if.iss_idx] = 1'b1;
      m_busy[0] = 1'b0;
      if (rf_if.pc_write_enable) m_pc = rf_if.pc_write_data;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_tests++;
    if (rf_if.pc_read_data !== RPC) begin
      n_fail++; $display("FAIL reset_pc got %h want %h", rf_if.pc_read_data, RPC);
    end
    for (int i = 0; i < NR; i++) begin
      rf_if.dbg_idx = 5'(i);
      rf_if.rd_idx  = {5'(i), 5'(i)};
      #1;
      n_tests++;
      if (rf_if.dbg_data !== 32'd0 || rf_if.rd_data !== 64'd0 || rf_if.rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_idx%0d dbg %h rd %h busy %b want 0", i, rf_if.dbg_data, rf_if.rd_data, rf_if.rd_busy);
      end
    end
  endtask

  task automatic test_x0();
    idle();
    rf_if.wr_en   = 2'b01;
    rf_if.wr_idx  = {5'd0, 5'd0};
    rf_if.wr_data = {32'd0, 32'hDEAD_BEEF};
    rf_if.iss_en  = 1'b1;
    rf_if.iss_idx = 5'd0;
    #1;
    n_tests++;
    if (rf_if.iss_stall !== 1'b0) begin
      n_fail++; $display("FAIL x0_stall got %b want 0", rf_if.iss_stall);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if (rf_if.rd_data !== 64'd0 || rf_if.rd_busy !== 2'b00 || rf_if.dbg_data !== 32'd0) begin
      n_fail++; $display("FAIL x0_read rd %h busy %b dbg %h want 0", rf_if.rd_data, rf_if.rd_busy, rf_if.dbg_data);
    end
  endtask

  task automatic test_write_read();
    idle();
    rf_if.wr_en   = 2'b01;
    rf_if.wr_idx  = {5'd0, 5'd5};
    rf_if.wr_data = {32'd0, 32'h1234_5678};
    rf_if.rd_idx  = {5'd5, 5'd5};
    rf_if.dbg_idx = 5'd5;
    #1;
    n_tests++;
`ifdef GENERAL_REGISTER_FILE_BYPASS_EN
    if (rf_if.rd_data !== {32'h1234_5678, 32'h1234_5678}) begin
`else
    if (rf_if.rd_data !== 64'd0) begin
`endif
      n_fail++; $display("FAIL wr_same_cycle got %h", rf_if.rd_data);
    end
    n_tests++;
    if (rf_if.dbg_data !== 32'd0) begin
      n_fail++; $display("FAIL dbg_no_bypass got %h want 0", rf_if.dbg_data);
    end
    tick();
    idle();
    rf_if.rd_idx  = {5'd5, 5'd5};
    rf_if.dbg_idx = 5'd5;
    #1;
    n_tests++;
    if (rf_if.rd_data !== {32'h1234_5678, 32'h1234_5678} || rf_if.dbg_data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wr_next_cycle rd %h dbg %h want 12345678", rf_if.rd_data, rf_if.dbg_data);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    rf_if.iss_en  = 1'b1;
    rf_if.iss_idx = 5'd7;
    #1;
    n_tests++;
    if (rf_if.iss_stall !== 1'b0) begin
      n_fail++; $display("FAIL sb_first_issue stall %b want 0", rf_if.iss_stall);
    end
    tick();
    idle();
    rf_if.rd_idx = {5'd7, 5'd7};
    #1;
    n_tests++;
    if (rf_if.rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL sb_busy_set got %b want 11", rf_if.rd_busy);
    end
    rf_if.iss_en  = 1'b1;
    rf_if.iss_idx = 5'd7;
    #1;
    n_tests++;
    if (rf_if.iss_stall !== 1'b1) begin
      n_fail++; $display("FAIL sb_reissue_stall got %b want 1", rf_if.iss_stall);
    end
    tick();
    idle();
    rf_if.rd_idx  = {5'd7, 5'd7};
    rf_if.wr_en   = 2'b01;
    rf_if.wr_idx  = {5'd0, 5'd7};
    rf_if.wr_data = {32'd0, 32'h0000_0077};
    #1;
    n_tests++;
`ifdef GENERAL_REGISTER_FILE_BYPASS_EN
    if (rf_if.rd_busy !== 2'b00) begin
`else
    if (rf_if.rd_busy !== 2'b11) begin
`endif
      n_fail++; $display("FAIL sb_wb_same_cycle busy %b", rf_if.rd_busy);
    end
    tick();
    idle();
    rf_if.rd_idx = {5'd7, 5'd7};
    #1;
    n_tests++;
    if (rf_if.rd_busy !== 2'b00 || rf_if.rd_data[31:0] !== 32'h0000_0077) begin
      n_fail++; $display("FAIL sb_cleared busy %b data %h want 00/77", rf_if.rd_busy, rf_if.rd_data[31:0]);
    end
  endtask

  task automatic test_collision();
    idle();
    rf_if.wr_en   = 2'b11;
    rf_if.wr_idx  = {5'd9, 5'd9};
    rf_if.wr_data = {32'h0000_000B, 32'h0000_000A};
    tick();
    idle();
    rf_if.rd_idx = {5'd9, 5'd9};
    #1;
    n_tests++;
    if (rf_if.rd_data !== {32'h0000_000B, 32'h0000_000B}) begin
      n_fail++; $display("FAIL coll_write got %h want B/B", rf_if.rd_data);
    end
    idle();
    rf_if.iss_en  = 1'b1;
    rf_if.iss_idx = 5'd3;
    rf_if.wr_en   = 2'b01;
    rf_if.wr_idx  = {5'd0, 5'd3};
    rf_if.wr_data = {32'd0, 32'h0000_0033};
    tick();
    idle();
    rf_if.rd_idx = {5'd3, 5'd3};
    #1;
    n_tests++;
    if (rf_if.rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL coll_issue_wb busy %b want 11", rf_if.rd_busy);
    end
    rf_if.wr_en  = 2'b10;
    rf_if.wr_idx = {5'd3, 5'd0};
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    rf_if.wr_en   = 2'b01;
    rf_if.wr_idx  = {5'd0, 5'd4};
    rf_if.wr_data = {32'd0, 32'h0000_0055};
    tick();
    idle();
    rf_if.iss_en          = 1'b1;
    rf_if.iss_idx         = 5'd4;
    rf_if.pc_write_enable = 1'b1;
    rf_if.pc_write_data   = 32'h0000_0100;
    tick();
    idle();
    rf_if.rd_idx = {5'd4, 5'd4};
    #1;
    n_tests++;
    if (rf_if.rd_busy !== 2'b11 || rf_if.pc_read_data !== 32'h100 || rf_if.rd_data[31:0] !== 32'h55) begin
      n_fail++; $display("FAIL mid_pre busy %b pc %h x4 %h", rf_if.rd_busy, rf_if.pc_read_data, rf_if.rd_data[31:0]);
    end
    rst                   = 1'b1;
    rf_if.pc_write_enable = 1'b1;
    rf_if.pc_write_data   = 32'h0000_0200;
    rf_if.iss_en          = 1'b1;
    rf_if.iss_idx         = 5'd6;
    tick();
    rst = 1'b0;
    idle();
    rf_if.rd_idx = {5'd6, 5'd4};
    #1;
    n_tests++;
    if (rf_if.rd_busy !== 2'b00 || rf_if.pc_read_data !== RPC || rf_if.rd_data[31:0] !== 32'd0) begin
      n_fail++; $display("FAIL mid_post busy %b pc %h x4 %h want 00/%h/0", rf_if.rd_busy, rf_if.pc_read_data, rf_if.rd_data[31:0], RPC);
    end
  endtask

  task automatic test_random();
    logic [4:0] ri;
    for (int c = 0; c < 400; c++) begin
      rst                   = ($urandom_range(0, 59) == 0);
      rf_if.rd_idx          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_if.wr_en           = 2'($urandom_range(0, 3));
      rf_if.wr_idx          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_if.wr_data         = {32'($urandom), 32'($urandom)};
      rf_if.iss_en          = 1'($urandom_range(0, 1));
      rf_if.iss_idx         = 5'($urandom_range(0, 7));
      rf_if.pc_write_enable = 1'($urandom_range(0, 1));
      rf_if.pc_write_data   = 32'($urandom);
      rf_if.dbg_idx         = 5'($urandom_range(0, 7));
      #1;
      for (int p = 0; p < NRD; p++) begin
        ri = rf_if.rd_idx[p*AWL +: AWL];
        n_tests++;
        if (rf_if.rd_data[p*XL +: XL] !== exp_rd(ri) || rf_if.rd_busy[p] !== exp_busy(ri)) begin
          n_fail++;
          $display("FAIL rnd%0d_port%0d x%0d data %h busy %b want %h %b", c, p, ri,
                   rf_if.rd_data[p*XL +: XL], rf_if.rd_busy[p], exp_rd(ri), exp_busy(ri));
        end
      end
      n_tests++;
      if (rf_if.iss_stall !== exp_busy(rf_if.iss_idx)) begin
        n_fail++; $display("FAIL rnd%0d_stall got %b want %b", c, rf_if.iss_stall, exp_busy(rf_if.iss_idx));
      end
      n_tests++;
      if (rf_if.pc_read_data !== m_pc || rf_if.dbg_data !== m_regs[rf_if.dbg_idx]) begin
        n_fail++;
        $display("FAIL rnd%0d_pc_dbg pc %h dbg %h want %h %h", c, rf_if.pc_read_data, rf_if.dbg_data, m_pc, m_regs[rf_if.dbg_idx]);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    m_busy  = 32'd0;
    m_pc    = RPC;
    for (int r = 0; r < NR; r++) m_regs[r] = 32'd0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_x0();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
